// File: rtl/dl_lock_sched.sv
// Round-robin owner of the per-frame calibration slot across NUM_LOCKS dl lockbox channels.
// Config bus: gpio_in[31:16] = register address, gpio_in[15:0] = data, latched whenever the address matches.
module dl_lock_sched #(
  parameter int unsigned NUM_LOCKS = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          gpio_in,
  input  logic                 enable,
  input  logic                 frame_start,
  input  logic [NUM_LOCKS-1:0] lock_done_in,
  input  logic [NUM_LOCKS-1:0] lock_err_in,
  output logic [NUM_LOCKS-1:0] trig_lock_out,
  output logic [NUM_LOCKS-1:0] lock_sig_active_out,
  output logic                 cal_pulse_req,
  output logic [3:0]           grant_idx,
  output logic                 relocking,
  output logic                 all_locked,
  output logic [NUM_LOCKS-1:0] err_out
);

  localparam int unsigned GW = 4;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, OBSERVE, RELOCK} state_t;

  state_t               state;
  logic [NUM_LOCKS-1:0] chan_mask;
  logic [CW-1:0]        obs_cycles;
  logic [CW-1:0]        relock_frames;
  logic [CW-1:0]        obs_cnt;
  logic [CW-1:0]        frm_cnt;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        nxt_grant;
  logic [NUM_LOCKS-1:0] active;
  logic [NUM_LOCKS-1:0] g_oh;
  logic [NUM_LOCKS-1:0] nxt_oh;
  logic                 g_active;
  logic                 g_done;
  logic                 g_err;

  // Configuration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chan_mask     <= '0;
      obs_cycles    <= '0;
      relock_frames <= '0;
    end else begin
      if (gpio_in[31:16] == CW'(BASE_ADDR))     chan_mask     <= gpio_in[NUM_LOCKS-1:0];
      if (gpio_in[31:16] == CW'(BASE_ADDR + 1)) obs_cycles    <= gpio_in[15:0];
      if (gpio_in[31:16] == CW'(BASE_ADDR + 2)) relock_frames <= gpio_in[15:0];
    end
  end

  assign active   = {NUM_LOCKS{enable}} & chan_mask & ~err_out;
  assign g_oh     = NUM_LOCKS'(1) << grant_idx;
  assign nxt_oh   = NUM_LOCKS'(1) << nxt_grant;
  assign g_active = |(active & g_oh);
  assign g_done   = |(lock_done_in & g_oh);
  assign g_err    = |(lock_err_in & g_oh);

  // First active channel strictly after last_grant, wrapping
  always_comb begin : pick_next
    int unsigned          idx;
    logic [NUM_LOCKS-1:0] act_sh;
    logic                 found;
    nxt_grant = '0;
    found     = 1'b0;
    idx       = 0;
    act_sh    = '0;
    for (int unsigned k = 1; k <= NUM_LOCKS; k++) begin
      idx    = (32'(last_grant) + k) % NUM_LOCKS;
      act_sh = active >> idx;
      if (!found && act_sh[0]) begin
        found     = 1'b1;
        nxt_grant = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      trig_lock_out       <= '0;
      lock_sig_active_out <= '0;
      cal_pulse_req       <= 1'b0;
      grant_idx           <= '0;
      relocking           <= 1'b0;
      all_locked          <= 1'b0;
      err_out             <= '0;
      last_grant          <= GW'(NUM_LOCKS - 1);
      obs_cnt             <= '0;
      frm_cnt             <= '0;
    end else begin
      trig_lock_out       <= active;
      all_locked          <= (|active) & (&(lock_done_in | ~active));
      lock_sig_active_out <= '0;
      cal_pulse_req       <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        err_out   <= '0;
        relocking <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SCAN;
          SCAN: begin
            if (frame_start && (|active)) begin
              grant_idx           <= nxt_grant;
              last_grant          <= nxt_grant;
              lock_sig_active_out <= nxt_oh;
              cal_pulse_req       <= 1'b1;
              state               <= ISSUE;
            end
          end
          ISSUE: begin
            if (!g_active) begin
              state <= SCAN;
            end else begin
              obs_cnt <= obs_cycles;
              state   <= OBSERVE;
            end
          end
          OBSERVE: begin
            if (!g_active) begin
              state <= SCAN;
            end else if (obs_cnt == '0) begin
              if (g_done) begin
                state <= SCAN;
              end else begin
                frm_cnt   <= '0;
                relocking <= 1'b1;
                state     <= RELOCK;
              end
            end else begin
              obs_cnt <= obs_cnt - CW'(1);
            end
          end
          RELOCK: begin
            // Done beats a same-cycle timeout; an error flag beats done
            if (!g_active || (g_done && !g_err)) begin
              relocking <= 1'b0;
              state     <= SCAN;
            end else if (g_err || frm_cnt == relock_frames) begin
              err_out   <= err_out | g_oh;
              relocking <= 1'b0;
              state     <= SCAN;
            end else if (frame_start) begin
              lock_sig_active_out <= g_oh;
              cal_pulse_req       <= 1'b1;
              frm_cnt             <= frm_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dl_lock_sched.sv
// Randomized scoreboard bench for dl_lock_sched using a frame-level reference model.
module tb_dl_lock_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  gpio_in = 32'hFFFF_0000;
  logic         enable = 1'b0;
  logic         frame_start = 1'b0;
  logic [N-1:0] lock_done_in = '0;
  logic [N-1:0] lock_err_in = '0;
  logic [N-1:0] trig_lock_out;
  logic [N-1:0] lock_sig_active_out;
  logic         cal_pulse_req;
  logic [3:0]   grant_idx;
  logic         relocking;
  logic         all_locked;
  logic [N-1:0] err_out;

  dl_lock_sched #(.NUM_LOCKS(N), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .enable(enable), .frame_start(frame_start),
    .lock_done_in(lock_done_in), .lock_err_in(lock_err_in), .trig_lock_out(trig_lock_out),
    .lock_sig_active_out(lock_sig_active_out), .cal_pulse_req(cal_pulse_req),
    .grant_idx(grant_idx), .relocking(relocking), .all_locked(all_locked), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_cyc_q[$];
  int exp_ch_q[$];

  // Reference model state (frame granularity)
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_err = '0;
  int  m_last = N - 1;
  int  m_g = 0;
  bit  m_rel = 1'b0;
  int  m_frm = 0;
  int  m_o = 0;
  int  m_r = 0;

  // Monitor: every strobe must match the oldest expectation in channel and cycle
  int           mon_cyc;
  int           mon_ch;
  logic [N-1:0] mon_want;
  always @(negedge clk) begin
    if (rst && (lock_sig_active_out != '0 || cal_pulse_req)) begin
      checks++;
      if (exp_ch_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d got strobe=%b cal=%b required none", cyc,
                 lock_sig_active_out, cal_pulse_req);
      end else begin
        mon_cyc  = exp_cyc_q.pop_front();
        mon_ch   = exp_ch_q.pop_front();
        mon_want = N'(1) << mon_ch;
        if (lock_sig_active_out !== mon_want || cal_pulse_req !== 1'b1 || cyc != mon_cyc) begin
          errors++;
          $display("FAIL strobe got=%b cal=%b cyc=%0d required=%b cal=1 cyc=%0d",
                   lock_sig_active_out, cal_pulse_req, cyc, mon_want, mon_cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  function automatic int next_after(input int last, input logic [N-1:0] act);
    for (int k = 1; k <= N; k++) begin
      if (act[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic cfg(input logic [N-1:0] mask, input int o, input int r);
    @(negedge clk); gpio_in = {16'd0, 16'(mask)};
    @(negedge clk); gpio_in = {16'd1, 16'(o)};
    @(negedge clk); gpio_in = {16'd2, 16'(r)};
    @(negedge clk); gpio_in = 32'hFFFF_0000;
    m_mask = mask; m_o = o; m_r = r;
  endtask

  task automatic set_enable(input logic en);
    @(negedge clk); enable = en;
    if (!en) begin
      m_err = '0; m_rel = 1'b0;
      repeat (2) @(negedge clk);
      chk("dis_trig", 32'(trig_lock_out), 32'd0);
      chk("dis_err", 32'(err_out), 32'd0);
      chk("dis_reloc", 32'(relocking), 32'd0);
      chk("dis_grant_held", 32'(grant_idx), 32'(m_g));
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  // One frame: new done/err vectors are applied the cycle after frame_start
  task automatic do_frame(input logic [N-1:0] nd, input logic [N-1:0] ne);
    logic [N-1:0] act;
    bit was_rel;
    bit served;
    int g;
    act = m_mask & ~m_err; was_rel = m_rel; served = 1'b0;
    @(negedge clk); frame_start = 1'b1;
    if (was_rel) begin
      exp_cyc_q.push_back(cyc + 1); exp_ch_q.push_back(m_g); m_frm++;
    end else begin
      g = next_after(m_last, act);
      if (g >= 0) begin
        m_last = g; m_g = g; served = 1'b1;
        exp_cyc_q.push_back(cyc + 1); exp_ch_q.push_back(g);
      end
    end
    @(negedge clk); frame_start = 1'b0; lock_done_in = nd; lock_err_in = ne;
    if (was_rel) begin
      if (nd[m_g] && !ne[m_g]) m_rel = 1'b0;
      else if (ne[m_g] || m_frm == m_r) begin m_err[m_g] = 1'b1; m_rel = 1'b0; end
    end else if (served && !nd[m_g]) begin
      m_rel = 1'b1; m_frm = 0;
      if (ne[m_g] || m_r == 0) begin m_err[m_g] = 1'b1; m_rel = 1'b0; end
    end
    repeat (m_o + 6) @(negedge clk);
    act = m_mask & ~m_err;
    chk("err_out", 32'(err_out), 32'(m_err));
    chk("trig_lock", 32'(trig_lock_out), 32'(act));
    chk("relocking", 32'(relocking), 32'(m_rel));
    chk("grant_idx", 32'(grant_idx), 32'(m_g));
    chk("all_locked", 32'(all_locked), 32'((act != '0) && ((nd | ~act) == '1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rnd_done;
    logic [N-1:0] rnd_err;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(trig_lock_out), 32'd0);
    chk("rst_strobe", 32'(lock_sig_active_out), 32'd0);
    chk("rst_cal", 32'(cal_pulse_req), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_reloc", 32'(relocking), 32'd0);
    chk("rst_locked", 32'(all_locked), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    rst = 1'b1;

    // Full rotation, all locked
    cfg(4'b1111, 2, 3);
    set_enable(1'b1);
    for (int k = 0; k < 8; k++) begin
      do_frame(4'b1111, 4'b0000);
      chk("rot4_grant", 32'(grant_idx), 32'(k % 4));
    end
    chk("rot4_all_locked", 32'(all_locked), 32'd1);

    // Sparse mask alternates ch0/ch2
    set_enable(1'b0);
    cfg(4'b0101, 2, 3);
    set_enable(1'b1);
    for (int k = 0; k < 4; k++) begin
      do_frame(4'b1111, 4'b0000);
      chk("rot2_grant", 32'(grant_idx), 32'((k % 2) * 2));
    end
    chk("rot2_trig", 32'(trig_lock_out), 32'b0101);

    // ch1 drops lock and recovers after three relock frames
    set_enable(1'b0);
    cfg(4'b1111, 10, 5);
    set_enable(1'b1);
    do_frame(4'b1111, 4'b0000);
    do_frame(4'b1111, 4'b0000);
    do_frame(4'b1101, 4'b0000);
    chk("relock_enter", 32'(relocking), 32'd1);
    do_frame(4'b1101, 4'b0000);
    do_frame(4'b1101, 4'b0000);
    do_frame(4'b1111, 4'b0000);
    do_frame(4'b1111, 4'b0000);
    chk("relock_then_ch2", 32'(grant_idx), 32'd2);

    // ch1 never relocks: fails after five relock frames and is skipped
    do_frame(4'b1111, 4'b0000);
    do_frame(4'b1111, 4'b0000);
    do_frame(4'b1101, 4'b0000);
    for (int k = 0; k < 5; k++) do_frame(4'b1101, 4'b0000);
    chk("timeout_err", 32'(err_out), 32'b0010);
    chk("timeout_trig", 32'(trig_lock_out), 32'b1101);
    for (int k = 0; k < 4; k++) begin
      do_frame(4'b1111, 4'b0000);
      chk("skip_grant", 32'(grant_idx), (k == 3) ? 32'd2 : 32'((k + 2) % 4 == 1 ? 0 : (k + 2) % 4));
    end

    // Enable dropped while relocking
    do_frame(4'b0000, 4'b0000);
    do_frame(4'b0000, 4'b0000);
    chk("pre_drop_reloc", 32'(relocking), 32'd1);
    set_enable(1'b0);

    // Done arrives on the same cycle the relock budget runs out
    cfg(4'b1111, 1, 2);
    set_enable(1'b1);
    do_frame(4'b0000, 4'b0000);
    do_frame(4'b0000, 4'b0000);
    do_frame(4'b1111, 4'b0000);
    chk("done_wins_err", 32'(err_out), 32'd0);
    chk("done_wins_reloc", 32'(relocking), 32'd0);

    // Randomized sessions
    for (int s = 0; s < 4; s++) begin
      set_enable(1'b0);
      cfg(N'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 4));
      set_enable(1'b1);
      for (int f = 0; f < 25; f++) begin
        for (int b = 0; b < N; b++) begin
          rnd_done[b] = ($urandom_range(0, 3) != 0);
          rnd_err[b]  = ($urandom_range(0, 7) == 0);
        end
        do_frame(rnd_done, rnd_err);
      end
    end

    // Asynchronous reset while the strobe is high
    set_enable(1'b0);
    cfg(4'b1111, 3, 3);
    set_enable(1'b1);
    @(negedge clk); frame_start = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; frame_start = 1'b0;
    #1;
    chk("arst_strobe", 32'(lock_sig_active_out), 32'd0);
    chk("arst_cal", 32'(cal_pulse_req), 32'd0);
    chk("arst_trig", 32'(trig_lock_out), 32'd0);
    chk("arst_grant", 32'(grant_idx), 32'd0);
    chk("arst_locked", 32'(all_locked), 32'd0);
    repeat (4) @(negedge clk);
    chk("pending_strobes", 32'(exp_ch_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
